// File: rtl/tri_pkg.sv
// tri_pkg: shared triangle types for the triangle-fetch receive path.
package tri_pkg;
    typedef logic [3:0][31:0] vertex_t;
    typedef struct packed {
        vertex_t v1;
        vertex_t v2;
        vertex_t v3;
        logic    last;
    } triangle_t;
    localparam int TRI_W = $bits(triangle_t);
endpackage

// File: rtl/triangle_receiver_if.sv
// triangle_receiver_if: producer-side ingest, downstream stream and object status signals.
interface triangle_receiver_if import tri_pkg::*; #(parameter int CNT_W = 16);
    vertex_t v1_in, v2_in, v3_in;
    logic valid_in, obj_done_in, ready_out;
    vertex_t v1_out, v2_out, v3_out;
    logic valid_out, last_out, ready_in;
    logic [CNT_W-1:0] obj_count_out;
    logic obj_count_valid_out, overflow_out;
    modport slave (
        input  v1_in, v2_in, v3_in, valid_in, obj_done_in, ready_in,
        output ready_out, v1_out, v2_out, v3_out, valid_out, last_out,
               obj_count_out, obj_count_valid_out, overflow_out
    );
    modport master (
        output v1_in, v2_in, v3_in, valid_in, obj_done_in, ready_in,
        input  ready_out, v1_out, v2_out, v3_out, valid_out, last_out,
               obj_count_out, obj_count_valid_out, overflow_out
    );
endinterface

// File: rtl/tri_fifo.sv
// tri_fifo: synchronous FIFO with count-based occupancy; head is read straight from storage.
module tri_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign do_pop = pop && !empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/triangle_receiver.sv
// triangle_receiver: buffers fetched triangles, re-issues them as a valid/ready stream,
// counts triangles per object and flags producer overflow.
module triangle_receiver import tri_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic clk_in,
    input logic rst_in,
    triangle_receiver_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [CW-1:0] count, count_nx;
    logic full, empty, push, pop;
    logic ready_q, ovf_q, cnt_vld_q;
    logic [CNT_W-1:0] run_cnt, run_inc, obj_cnt_q;
    logic [TRI_W-1:0] dout;
    triangle_t din, head;
    assign din = '{v1: bus.v1_in, v2: bus.v2_in, v3: bus.v3_in, last: bus.obj_done_in};
    assign head = triangle_t'(dout);
    assign pop = !empty && bus.ready_in;
    assign push = bus.valid_in && (!full || pop);
    assign count_nx = count + CW'(push) - CW'(pop);
    assign run_inc = (run_cnt == '1) ? run_cnt : run_cnt + CNT_W'(1);
    tri_fifo #(.WIDTH(TRI_W), .DEPTH(DEPTH)) u_fifo (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .push(push),
        .pop(pop),
        .din(din),
        .dout(dout),
        .count(count),
        .full(full),
        .empty(empty)
    );
    // ready keeps one slot spare for a triangle committed on the previous ready sample
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ready_q <= 1'b0;
            ovf_q <= 1'b0;
            cnt_vld_q <= 1'b0;
            obj_cnt_q <= '0;
            run_cnt <= '0;
        end else begin
            ready_q <= count_nx <= CW'(DEPTH - 2);
            cnt_vld_q <= push && bus.obj_done_in;
            if (bus.valid_in && !push) ovf_q <= 1'b1;
            if (push) begin
                run_cnt <= bus.obj_done_in ? '0 : run_inc;
                if (bus.obj_done_in) obj_cnt_q <= run_inc;
            end
        end
    end
    assign bus.ready_out = ready_q;
    assign bus.v1_out = head.v1;
    assign bus.v2_out = head.v2;
    assign bus.v3_out = head.v3;
    assign bus.last_out = !empty && head.last;
    assign bus.valid_out = !empty;
    assign bus.obj_count_out = obj_cnt_q;
    assign bus.obj_count_valid_out = cnt_vld_q;
    assign bus.overflow_out = ovf_q;
endmodule

// File: tb/tb_triangle_receiver.sv
// tb_triangle_receiver: directed checks of buffering, flow control, overflow and object counting.
module tb_triangle_receiver;
    import tri_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    triangle_t rcv[$];
    int cq[$];
    triangle_receiver_if #(.CNT_W(16)) bus ();
    triangle_receiver #(.DEPTH(4), .CNT_W(16)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (!rst && bus.valid_out && bus.ready_in)
            rcv.push_back('{v1: bus.v1_out, v2: bus.v2_out, v3: bus.v3_out, last: bus.last_out});
        if (bus.obj_count_valid_out) cq.push_back(int'(bus.obj_count_out));
    end
    task automatic check(input string tag, input logic [TRI_W-1:0] got, input logic [TRI_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic triangle_t mk(input int id, input logic last);
        mk.v1 = {32'(id), 32'(id + 1), 32'(id + 2), 32'd1};
        mk.v2 = {32'(id + 10), 32'(id + 11), 32'(id + 12), 32'd1};
        mk.v3 = {32'(id + 20), 32'(id + 21), 32'(id + 22), 32'd1};
        mk.last = last;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input triangle_t t);
        bus.v1_in = t.v1;
        bus.v2_in = t.v2;
        bus.v3_in = t.v3;
        bus.obj_done_in = t.last;
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        bus.obj_done_in = 1'b0;
    endtask
    function automatic triangle_t head();
        head = '{v1: bus.v1_out, v2: bus.v2_out, v3: bus.v3_out, last: bus.last_out};
    endfunction
    task automatic cmp_rcv(input string tag, input int base, input int n, input int last_idx);
        check({tag, "_n"}, rcv.size(), n);
        for (int i = 0; i < n && i < rcv.size(); i++) check(tag, rcv[i], mk(base + i, i == last_idx));
        rcv.delete();
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask
    initial begin
        int n;
        bus.v1_in = '0;
        bus.v2_in = '0;
        bus.v3_in = '0;
        bus.valid_in = 1'b0;
        bus.obj_done_in = 1'b0;
        bus.ready_in = 1'b0;
        repeat (3) tick();
        check("rst_ready", bus.ready_out, 0);
        check("rst_valid", bus.valid_out, 0);
        check("rst_last", bus.last_out, 0);
        check("rst_cnt", bus.obj_count_out, 0);
        check("rst_cnt_vld", bus.obj_count_valid_out, 0);
        check("rst_ovf", bus.overflow_out, 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", bus.ready_out, 1);
        // single-triangle object
        bus.ready_in = 1'b1;
        send(mk(1, 1'b1));
        check("t1_valid", bus.valid_out, 1);
        check("t1_data", head(), mk(1, 1'b1));
        check("t1_v1x", bus.v1_out[3], 1);
        check("t1_cnt", bus.obj_count_out, 1);
        check("t1_cnt_vld", bus.obj_count_valid_out, 1);
        tick();
        check("t1_empty", bus.valid_out, 0);
        check("t1_cnt_pulse", bus.obj_count_valid_out, 0);
        cmp_rcv("t1_rcv", 1, 1, 0);
        cq.delete();
        // twelve-triangle object at 11-cycle spacing
        for (int i = 0; i < 12; i++) begin
            send(mk(100 + i, i == 11));
            repeat (10) tick();
        end
        cmp_rcv("t2_rcv", 100, 12, 11);
        check("t2_cq_n", cq.size(), 1);
        if (cq.size() > 0) check("t2_cq", cq[0], 12);
        cq.delete();
        // producer honouring ready with a stalled consumer
        bus.ready_in = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.ready_out) begin
                tick();
                send(mk(300 + n, 1'b0));
                n++;
            end else tick();
        end
        check("t3_pushes", n, 3);
        check("t3_ready", bus.ready_out, 0);
        check("t3_ovf", bus.overflow_out, 0);
        check("t3_head", head(), mk(300, 1'b0));
        bus.ready_in = 1'b1;
        repeat (5) tick();
        cmp_rcv("t3_rcv", 300, 3, -1);
        check("t3_ready_back", bus.ready_out, 1);
        // forced overflow
        bus.ready_in = 1'b0;
        for (int i = 0; i < 5; i++) send(mk(400 + i, 1'b0));
        check("t4_ovf", bus.overflow_out, 1);
        repeat (3) tick();
        check("t4_ovf_held", bus.overflow_out, 1);
        check("t4_head_stable", head(), mk(400, 1'b0));
        bus.ready_in = 1'b1;
        repeat (6) tick();
        cmp_rcv("t4_rcv", 400, 4, -1);
        check("t4_ovf_sticky", bus.overflow_out, 1);
        do_reset();
        check("t4_ovf_clr", bus.overflow_out, 0);
        // full FIFO with simultaneous push and pop
        bus.ready_in = 1'b0;
        for (int i = 0; i < 4; i++) send(mk(500 + i, 1'b0));
        check("t5_full_ready", bus.ready_out, 0);
        bus.ready_in = 1'b1;
        send(mk(504, 1'b0));
        bus.ready_in = 1'b0;
        check("t5_count", dut.count, 4);
        check("t5_ovf", bus.overflow_out, 0);
        check("t5_head", head(), mk(501, 1'b0));
        bus.ready_in = 1'b1;
        repeat (6) tick();
        cmp_rcv("t5_rcv", 500, 5, -1);
        cq.delete();
        // reset mid-object discards buffered triangles and the running count
        bus.ready_in = 1'b0;
        for (int i = 0; i < 3; i++) send(mk(600 + i, 1'b0));
        check("t6_pre_valid", bus.valid_out, 1);
        rst = 1'b1;
        tick();
        check("t6_valid", bus.valid_out, 0);
        check("t6_ready", bus.ready_out, 0);
        rst = 1'b0;
        tick();
        check("t6_ready_back", bus.ready_out, 1);
        rcv.delete();
        bus.ready_in = 1'b1;
        send(mk(610, 1'b1));
        check("t6_cnt", bus.obj_count_out, 1);
        check("t6_cnt_vld", bus.obj_count_valid_out, 1);
        check("t6_head", head(), mk(610, 1'b1));
        tick();
        cmp_rcv("t6_rcv", 610, 1, 0);
        check("t6_cq_n", cq.size(), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
